vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vending_machine_param.sv | 127 ++++++++++++
 tb/tb_vending_machine_param.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_param
// Purpose  : Coin-operated vending controller with a parameterised item price.
//            It accepts nickels, dimes and quarters and vends one item once the
//            credit reaches PRICE_N nickels. Any excess credit is returned one
//            nickel per cycle. A cancel request refunds the whole credit.
//            Coins that cannot be taken are reported on o_reject.
// Ports    : i_clk      - rising-edge clock
//            i_rst_n    - asynchronous active-low reset
//            i_nickle   - 5c coin pulse
//            i_dime     - 10c coin pulse
//            i_quarter  - 25c coin pulse
//            i_cancel   - refund request (level)
//            o_soda     - one-cycle dispense pulse
//            o_change   - one pulse per nickel returned
//            o_reject   - coin(s) of previous cycle returned uncredited
//            o_credit   - current credit in nickels
//            o_busy     - vending or returning change
// Revision : 1.0 - initial release
// ============================================================================
module vending_machine_param #(
  parameter int unsigned PRICE_N  = 4,
  parameter int unsigned CREDIT_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_cancel,
  output logic                o_soda,
  output logic                o_change,
  output logic                o_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_e;

  // One extra bit so that credit + coin can be compared without wrapping.
  localparam logic [CREDIT_W:0]   C_PRICE_X = (CREDIT_W+1)'(PRICE_N);
  localparam logic [CREDIT_W-1:0] C_PRICE   = CREDIT_W'(PRICE_N);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [1:0]          coin_cnt;
  logic                accepting;
  logic                coin_valid;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   credit_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    coin_cnt   = {1'b0, i_nickle} + {1'b0, i_dime} + {1'b0, i_quarter};
    accepting  = (state_q == S_IDLE) || (state_q == S_COLLECT);
    coin_valid = accepting && (coin_cnt == 2'd1);

    coin_val = '0;
    if (coin_valid) begin
      if (i_nickle)      coin_val = (CREDIT_W+1)'(1);
      else if (i_dime)   coin_val = (CREDIT_W+1)'(2);
      else               coin_val = (CREDIT_W+1)'(5);
    end
    credit_sum = {1'b0, credit_q} + coin_val;

    // Simultaneous coins, or any coin while busy, are bounced back.
    reject_d = (coin_cnt > 2'd1) || ((coin_cnt != 2'd0) && !accepting);

    state_d  = state_q;
    credit_d = credit_q;
    o_soda   = 1'b0;
    o_change = 1'b0;
    o_busy   = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        credit_d = credit_sum[CREDIT_W-1:0];
        // Cancel wins over vend: a same-cycle coin is credited, then refunded.
        if (i_cancel && (credit_sum != '0)) begin
          state_d = S_CHANGE;
        end else if (coin_valid) begin
          state_d = (credit_sum >= C_PRICE_X) ? S_VEND : S_COLLECT;
        end
      end
      S_VEND: begin
        o_soda   = 1'b1;
        o_busy   = 1'b1;
        credit_d = credit_q - C_PRICE;
        state_d  = (credit_q == C_PRICE) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        o_change = 1'b1;
        o_busy   = 1'b1;
        credit_d = credit_q - CREDIT_W'(1);
        if (credit_q == CREDIT_W'(1)) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  assign o_credit = credit_q;
  assign o_reject = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_param
// Purpose  : Self-checking bench for vending_machine_param (PRICE_N = 4).
//            Directed scenarios plus randomized coin/cancel traffic compared
//            against a transaction-level model of credit, vend and refund.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_machine_param;

  localparam int PRICE = 4;
  localparam int CW    = 5;

  logic          clk;
  logic          rst_n;
  logic          nickle, dime, quarter, cancel;
  logic          soda, change, reject, busy;
  logic [CW-1:0] credit;

  int checks;
  int failures;

  // Reference model: credit held, whether a vend is owed this cycle,
  // whether a refund is in progress, and the pending reject flag.
  int m_credit;
  bit m_vend;
  bit m_refund;
  bit m_rej;

  vending_machine_param #(.PRICE_N(PRICE), .CREDIT_W(CW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_nickle (nickle),
    .i_dime   (dime),
    .i_quarter(quarter),
    .i_cancel (cancel),
    .o_soda   (soda),
    .o_change (change),
    .o_reject (reject),
    .o_credit (credit),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_credit = 0;
    m_vend   = 1'b0;
    m_refund = 1'b0;
    m_rej    = 1'b0;
  endtask

  // Advance the model by one clock using the coin/cancel rules.
  task automatic model_step(input bit n, input bit d, input bit q, input bit c);
    int ncoins;
    int add;
    bit was_busy;
    ncoins   = int'(n) + int'(d) + int'(q);
    was_busy = m_vend || m_refund;
    m_rej    = (ncoins > 1) || (ncoins > 0 && was_busy);
    if (m_vend) begin
      m_credit = m_credit - PRICE;
      m_vend   = 1'b0;
      m_refund = (m_credit > 0);
    end else if (m_refund) begin
      m_credit = m_credit - 1;
      m_refund = (m_credit > 0);
    end else begin
      add = 0;
      if (ncoins == 1) add = n ? 1 : (d ? 2 : 5);
      m_credit = m_credit + add;
      if (c && m_credit > 0)                 m_refund = 1'b1;
      else if (add > 0 && m_credit >= PRICE) m_vend   = 1'b1;
    end
  endtask

  // Drive one cycle of inputs; returns 1 ns after the rising edge.
  task automatic cycle(input bit n, input bit d, input bit q, input bit c);
    nickle  = n;
    dime    = d;
    quarter = q;
    cancel  = c;
    model_step(n, d, q, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nickle  = 1'b0;
    dime    = 1'b0;
    quarter = 1'b0;
    cancel  = 1'b0;
    rst_n   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({soda, change, reject, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got soda/change/reject/busy=%b expected 0000",
               {soda, change, reject, busy});
    end
    checks++;
    if (credit !== 5'd0) begin
      failures++;
      $display("FAIL reset_credit: got %0d expected 0", credit);
    end
    // First edge after release must take the coin.
    cycle(0, 1, 0, 0);
    checks++;
    if (credit !== 5'd2) begin
      failures++;
      $display("FAIL first_coin: got credit %0d expected 2", credit);
    end
  endtask

  task automatic test_nickels();
    int nchg;
    int nsoda;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (credit !== CW'(i)) begin
        failures++;
        $display("FAIL nickel_credit_%0d: got %0d expected %0d", i, credit, i);
      end
      if (i < 4) cycle(0, 0, 0, 0);
    end
    checks++;
    if (soda !== 1'b1) begin
      failures++;
      $display("FAIL nickel_soda: got %b expected 1", soda);
    end
    nchg  = 0;
    nsoda = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      nchg  += int'(change);
      nsoda += int'(soda);
    end
    checks++;
    if (nchg != 0 || nsoda != 0) begin
      failures++;
      $display("FAIL nickel_after: got change=%0d soda=%0d expected 0 0", nchg, nsoda);
    end
    checks++;
    if (credit !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nickel_idle: got credit=%0d busy=%b expected 0 0", credit, busy);
    end
  endtask

  task automatic test_quarter();
    int nchg;
    int nsoda;
    do_reset();
    cycle(0, 0, 1, 0);
    checks++;
    if (credit !== 5'd5 || soda !== 1'b1) begin
      failures++;
      $display("FAIL quarter_vend: got credit=%0d soda=%b expected 5 1", credit, soda);
    end
    nchg  = 0;
    nsoda = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      nchg  += int'(change);
      nsoda += int'(soda);
    end
    checks++;
    if (nchg != 1 || nsoda != 0) begin
      failures++;
      $display("FAIL quarter_change: got change=%0d soda=%0d expected 1 0", nchg, nsoda);
    end
    checks++;
    if (credit !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL quarter_idle: got credit=%0d busy=%b expected 0 0", credit, busy);
    end
  endtask

  task automatic test_cancel();
    int nchg;
    int nsoda;
    int run;
    int maxrun;
    do_reset();
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (credit !== 5'd3) begin
      failures++;
      $display("FAIL cancel_credit: got %0d expected 3", credit);
    end
    nchg   = 0;
    nsoda  = 0;
    run    = 0;
    maxrun = 0;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      nchg  += int'(change);
      nsoda += int'(soda);
      run    = change ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      cycle(0, 0, 0, 0);
    end
    checks++;
    if (nchg != 3 || maxrun != 3 || nsoda != 0) begin
      failures++;
      $display("FAIL cancel_refund: got change=%0d run=%0d soda=%0d expected 3 3 0",
               nchg, maxrun, nsoda);
    end
  endtask

  task automatic test_reject();
    int  nchg;
    bit  rej_seen;
    do_reset();
    cycle(1, 1, 0, 0);
    checks++;
    if (reject !== 1'b1 || credit !== 5'd0) begin
      failures++;
      $display("FAIL multi_coin: got reject=%b credit=%0d expected 1 0", reject, credit);
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (reject !== 1'b0) begin
      failures++;
      $display("FAIL reject_width: got reject=%b expected 0", reject);
    end
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    nchg     = int'(change);
    rej_seen = 1'b0;
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      nchg    += int'(change);
      rej_seen = rej_seen | reject;
      cycle(0, 0, 0, 0);
    end
    checks++;
    if (nchg != 3 || rej_seen !== 1'b1 || credit !== 5'd0) begin
      failures++;
      $display("FAIL busy_coin: got change=%0d reject=%b credit=%0d expected 3 1 0",
               nchg, rej_seen, credit);
    end
  endtask

  task automatic test_reset_mid_change();
    int n;
    do_reset();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if (change !== 1'b1 || credit !== 5'd1) begin
      failures++;
      $display("FAIL pre_reset_change: got change=%b credit=%0d expected 1 1", change, credit);
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({soda, change, reject, busy} !== 4'b0000 || credit !== 5'd0) begin
      failures++;
      $display("FAIL async_reset: got flags=%b credit=%0d expected 0000 0",
               {soda, change, reject, busy}, credit);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      n += int'(change) + int'(soda);
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL post_reset_pulses: got %0d expected 0", n);
    end
  endtask

  task automatic test_cancel_with_coin();
    int nchg;
    int nsoda;
    do_reset();
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    checks++;
    if (credit !== 5'd4 || soda !== 1'b0) begin
      failures++;
      $display("FAIL cancel_coin_credit: got credit=%0d soda=%b expected 4 0", credit, soda);
    end
    nchg  = 0;
    nsoda = 0;
    for (int i = 0; i < 7; i++) begin
      nchg  += int'(change);
      nsoda += int'(soda);
      cycle(0, 0, 0, 0);
    end
    checks++;
    if (nchg != 4 || nsoda != 0) begin
      failures++;
      $display("FAIL cancel_coin_refund: got change=%0d soda=%0d expected 4 0", nchg, nsoda);
    end
  endtask

  task automatic test_random();
    int       r;
    bit       n, d, q, c;
    logic [8:0] got;
    logic [8:0] exp;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      n = (r == 0) || (r == 3) || (r == 6);
      d = (r == 1) || (r == 3) || (r == 5) || (r == 6);
      q = (r == 2) || (r == 6) || (r == 7);
      c = (r == 4) || (r == 5);
      cycle(n, d, q, c);
      got = {soda, change, reject, busy, credit};
      exp = {m_vend, m_refund, m_rej, m_vend | m_refund, CW'(m_credit)};
      checks++;
      if (got !== exp || m_credit > PRICE + 4) begin
        failures++;
        $display("FAIL random_cycle_%0d: got soda/chg/rej/busy/credit=%b/%0d expected %b/%0d",
                 i, got[8:5], got[4:0], exp[8:5], exp[4:0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    nickle   = 1'b0;
    dime     = 1'b0;
    quarter  = 1'b0;
    cancel   = 1'b0;
    model_clear();
    test_reset();
    test_nickels();
    test_quarter();
    test_cancel();
    test_reject();
    test_reset_mid_change();
    test_cancel_with_coin();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
